// File: rtl/aes_cipher_collector.sv
// Reassembles the serial AES ciphertext byte stream into one block and presents it on valid/ready.
// Latency: 1 cycle from the last byte of a block to cipher_valid when the output register is free.
// Backpressure: one block of skid storage; input bytes cannot be stalled, so bytes arriving while both blocks are held are dropped and flag overrun.
module aes_cipher_collector #(
    parameter int BLOCK_BYTES = 16,
    parameter int LSB_FIRST   = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [7:0]                     in_byte,
    input  logic                           in_valid,
    input  logic                           clr,
    output logic [8*BLOCK_BYTES-1:0]       cipher_out,
    output logic                           cipher_valid,
    input  logic                           cipher_ready,
    output logic [$clog2(BLOCK_BYTES)-1:0] byte_cnt,
    output logic                           overrun,
    output logic [15:0]                    block_count
);

    localparam int            CW       = $clog2(BLOCK_BYTES);
    localparam int            W        = 8 * BLOCK_BYTES;
    localparam logic [CW-1:0] LAST_IDX = CW'(BLOCK_BYTES - 1);

    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_FULL    = 1'b1;

    logic [0:0]    state_q,   state_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    logic [W-1:0]  asm_q,     asm_d;
    logic [W-1:0]  out_q,     out_d;
    logic          out_vld_q, out_vld_d;
    logic          overrun_q, overrun_d;
    logic [15:0]   blk_cnt_q, blk_cnt_d;

    logic [CW-1:0] slot;
    logic [W-1:0]  asm_ins;
    logic          out_fire;
    logic          out_free;

    // Slot of the incoming byte inside the block depends on the configured byte order.
    always_comb begin
        slot    = (LSB_FIRST != 0) ? cnt_q : (LAST_IDX - cnt_q);
        asm_ins = asm_q;
        asm_ins[{slot, 3'b000} +: 8] = in_byte;
    end

    assign out_fire = out_vld_q && cipher_ready;
    assign out_free = !out_vld_q || cipher_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        asm_d     = asm_q;
        out_d     = out_q;
        out_vld_d = out_vld_q;
        overrun_d = overrun_q;
        blk_cnt_d = blk_cnt_q;

        if (out_fire) begin
            out_vld_d = 1'b0;
            blk_cnt_d = blk_cnt_q + 16'd1;
        end

        // clr aborts assembly (including a held full block) but never touches the output register.
        if (clr) begin
            state_d   = ST_COLLECT;
            cnt_d     = '0;
            asm_d     = '0;
            overrun_d = 1'b0;
        end else begin
            case (state_q)
                ST_COLLECT: begin
                    if (in_valid) begin
                        asm_d = asm_ins;
                        if (cnt_q != LAST_IDX) begin
                            cnt_d = cnt_q + CW'(1);
                        end else if (out_free) begin
                            out_d     = asm_ins;
                            out_vld_d = 1'b1;
                            cnt_d     = '0;
                        end else begin
                            state_d = ST_FULL;
                        end
                    end
                end
                ST_FULL: begin
                    if (in_valid) begin
                        overrun_d = 1'b1;
                    end
                    if (out_free) begin
                        out_d     = asm_q;
                        out_vld_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = ST_COLLECT;
                    end
                end
                default: begin
                    state_d = ST_COLLECT;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_COLLECT;
            cnt_q     <= '0;
            asm_q     <= '0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
            overrun_q <= 1'b0;
            blk_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            asm_q     <= asm_d;
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
            overrun_q <= overrun_d;
            blk_cnt_q <= blk_cnt_d;
        end
    end

    assign cipher_out   = out_q;
    assign cipher_valid = out_vld_q;
    assign byte_cnt     = cnt_q;
    assign overrun      = overrun_q;
    assign block_count  = blk_cnt_q;

endmodule

// File: tb/tb_aes_cipher_collector.sv
// Self-checking bench: both byte orders side by side against a queue-based model of blocks in flight.
module tb_aes_cipher_collector;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   in_byte;
    logic         in_valid;
    logic         clr;
    logic         cipher_ready;

    logic [127:0] out_l,  out_m;
    logic         vld_l,  vld_m;
    logic [3:0]   cnt_l,  cnt_m;
    logic         ovr_l,  ovr_m;
    logic [15:0]  blk_l,  blk_m;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    aes_cipher_collector #(.BLOCK_BYTES(16), .LSB_FIRST(1)) dut_lsb (
        .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .clr(clr),
        .cipher_out(out_l), .cipher_valid(vld_l), .cipher_ready(cipher_ready),
        .byte_cnt(cnt_l), .overrun(ovr_l), .block_count(blk_l)
    );

    aes_cipher_collector #(.BLOCK_BYTES(16), .LSB_FIRST(0)) dut_msb (
        .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .clr(clr),
        .cipher_out(out_m), .cipher_valid(vld_m), .cipher_ready(cipher_ready),
        .byte_cnt(cnt_m), .overrun(ovr_m), .block_count(blk_m)
    );

    // Model: completed blocks (front = output register, second = held block), partial byte list.
    logic [127:0] m_blocks[$];
    logic [7:0]   m_part[$];
    logic         m_overrun;
    logic [15:0]  m_count;
    logic [127:0] m_last;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [127:0] byte_rev(input logic [127:0] w);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*(15-k) +: 8] = w[8*k +: 8];
        return r;
    endfunction

    task automatic model_edge();
        bit           full0;
        logic [127:0] w;
        if (rst) begin
            m_blocks.delete();
            m_part.delete();
            m_overrun = 1'b0;
            m_count   = 16'd0;
            m_last    = '0;
            return;
        end
        full0 = (m_blocks.size() == 2);
        if (clr && full0) void'(m_blocks.pop_back());
        if (m_blocks.size() > 0 && cipher_ready) begin
            void'(m_blocks.pop_front());
            m_count = m_count + 16'd1;
        end
        if (clr) begin
            m_part.delete();
            m_overrun = 1'b0;
        end else if (in_valid) begin
            if (full0) begin
                m_overrun = 1'b1;
            end else begin
                m_part.push_back(in_byte);
                if (m_part.size() == 16) begin
                    w = '0;
                    foreach (m_part[k]) w[8*k +: 8] = m_part[k];
                    m_blocks.push_back(w);
                    m_part.delete();
                end
            end
        end
        if (m_blocks.size() > 0) m_last = m_blocks[0];
    endtask

    task automatic step();
        logic [3:0] exp_cnt;
        model_edge();
        @(posedge clk);
        #1;
        exp_cnt = (m_blocks.size() == 2) ? 4'd15 : 4'(m_part.size());
        check_val("valid_lsb", 128'(vld_l), 128'(m_blocks.size() > 0));
        check_val("valid_msb", 128'(vld_m), 128'(m_blocks.size() > 0));
        check_val("out_lsb",   out_l, m_last);
        check_val("out_msb",   out_m, byte_rev(m_last));
        check_val("cnt_lsb",   128'(cnt_l), 128'(exp_cnt));
        check_val("cnt_msb",   128'(cnt_m), 128'(exp_cnt));
        check_val("ovr_lsb",   128'(ovr_l), 128'(m_overrun));
        check_val("ovr_msb",   128'(ovr_m), 128'(m_overrun));
        check_val("blk_lsb",   128'(blk_l), 128'(m_count));
        check_val("blk_msb",   128'(blk_m), 128'(m_count));
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_byte  = b;
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [127:0] exp;
        rst = 1'b1; in_byte = '0; in_valid = 1'b0; clr = 1'b0; cipher_ready = 1'b0;
        m_overrun = 1'b0; m_count = '0; m_last = '0;
        do_reset();
        check_val("rst_out",   out_l, 128'd0);
        check_val("rst_valid", 128'(vld_l), 128'd0);
        check_val("rst_cnt",   128'(cnt_l), 128'd0);

        // Incrementing stream, both byte orders.
        cipher_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(8'(i));
        check_val("t1_valid", 128'(vld_l), 128'd1);
        check_val("t1_out",   out_l, 128'h0F0E0D0C0B0A09080706050403020100);
        check_val("t2_out",   out_m, 128'h000102030405060708090A0B0C0D0E0F);
        step();
        check_val("t1_blk",   128'(blk_l), 128'd1);

        // Stalled consumer: second block parks in the skid slot.
        do_reset();
        cipher_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(8'hAA);
        for (int i = 0; i < 16; i++) send(8'hBB);
        check_val("t3_out_a", out_l, {16{8'hAA}});
        check_val("t3_cnt",   128'(cnt_l), 128'd15);
        cipher_ready = 1'b1;
        step();
        cipher_ready = 1'b0;
        check_val("t3_out_b", out_l, {16{8'hBB}});
        check_val("t3_valid", 128'(vld_l), 128'd1);
        check_val("t3_blk",   128'(blk_l), 128'd1);
        check_val("t3_ovr",   128'(ovr_l), 128'd0);

        // Byte arriving while both blocks are held is dropped.
        do_reset();
        for (int i = 0; i < 16; i++) send(8'hAA);
        for (int i = 0; i < 16; i++) send(8'hBB);
        send(8'hCC);
        check_val("t4_ovr", 128'(ovr_l), 128'd1);
        cipher_ready = 1'b1;
        step();
        cipher_ready = 1'b0;
        step();
        check_val("t4_out_b",  out_l, {16{8'hBB}});
        check_val("t4_ovr_st", 128'(ovr_l), 128'd1);
        cipher_ready = 1'b1;
        step();
        check_val("t4_blk", 128'(blk_l), 128'd2);

        // Partial block aborted by clr; the byte in the clr cycle is discarded.
        for (int i = 0; i < 5; i++) send(8'($urandom_range(0, 255)));
        clr = 1'b1;
        send(8'h55);
        clr = 1'b0;
        check_val("t5_cnt", 128'(cnt_l), 128'd0);
        check_val("t5_ovr", 128'(ovr_l), 128'd0);
        for (int i = 0; i < 16; i++) send(8'(8'h10 + i));
        check_val("t5_out", out_l, 128'h1F1E1D1C1B1A19181716151413121110);

        // Reset in the middle of a block with an output pending.
        step();
        cipher_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(8'($urandom_range(0, 255)));
        for (int i = 0; i < 7; i++) send(8'($urandom_range(0, 255)));
        check_val("t6_cnt7", 128'(cnt_l), 128'd7);
        check_val("t6_vld1", 128'(vld_l), 128'd1);
        do_reset();
        check_val("t6_out",   out_l, 128'd0);
        check_val("t6_valid", 128'(vld_l), 128'd0);
        check_val("t6_cnt",   128'(cnt_l), 128'd0);
        check_val("t6_blk",   128'(blk_l), 128'd0);
        exp = '0;
        for (int i = 0; i < 16; i++) begin
            exp[8*i +: 8] = 8'(8'h20 + i);
            send(8'(8'h20 + i));
        end
        check_val("t6_fresh", out_l, exp);

        // Randomized traffic with occasional clr and reset.
        for (int c = 0; c < 3000; c++) begin
            in_valid     = ($urandom_range(0, 99) < 70);
            in_byte      = 8'($urandom_range(0, 255));
            cipher_ready = ($urandom_range(0, 99) < 45);
            clr          = ($urandom_range(0, 99) < 2);
            rst          = ($urandom_range(0, 999) < 4);
            step();
        end
        rst = 1'b0; clr = 1'b0; in_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/aes_cipher_collector.md
Name: aes_cipher_collector

Overview:
Downstream stage of the AES encryption core. Consumes the serial ciphertext byte stream (`state_out_byte` qualified by `ready`) and reassembles it into a 128-bit ciphertext word. Presents the word on a valid/ready handshake to the consumer (DMA/packer), with one block of skid buffering so a stalled consumer never corrupts a block in flight.

Parameters:
- BLOCK_BYTES, 16, bytes per ciphertext block; the output width is 8*BLOCK_BYTES.
- LSB_FIRST, 1, 1: first byte received lands in bits [7:0]; 0: first byte lands in the top byte.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_byte  input  8  ciphertext byte from the core (`state_out_byte`).
- in_valid  input  1  byte-qualifier from the core (`ready`); one byte per high cycle, no backpressure.
- clr  input  1  synchronous abort of the partial block; clears overrun.
- cipher_out  output  8*BLOCK_BYTES  assembled ciphertext block.
- cipher_valid  output  1  cipher_out holds a complete block.
- cipher_ready  input  1  consumer accepts cipher_out when high with cipher_valid.
- byte_cnt  output  $clog2(BLOCK_BYTES)  bytes held in the partial block.
- overrun  output  1  sticky: a byte was dropped.
- block_count  output  16  blocks handed off (count of valid & ready handshakes); wraps at 16'hFFFF -> 0.

Behaviour:
- Reset (clk edge with rst=1): cipher_out=0, cipher_valid=0, byte_cnt=0, overrun=0, block_count=0, assembly register=0, FSM=COLLECT. rst overrides clr and all other inputs.
- Storage: assembly register asm_q (one block) and output register out_q (drives cipher_out).
- Byte placement: byte index k (0..BLOCK_BYTES-1).
  - LSB_FIRST=1: goes to asm_q[8k+:8].
  - LSB_FIRST=0: goes to asm_q[8*(BLOCK_BYTES-1-k)+:8].
- FSM states:
  - COLLECT, in_valid=1, k < BLOCK_BYTES-1: store byte; byte_cnt++.
  - COLLECT, in_valid=1, k = BLOCK_BYTES-1, out_q free: the completed block (including this byte) loads out_q on the same edge. cipher_valid=1 the next cycle (1-cycle latency from the last byte). byte_cnt->0; stay in COLLECT.
  - COLLECT, same as above but out_q occupied: store byte; go to FULL; byte_cnt stays at BLOCK_BYTES-1 (terminal-count indication).
  - FULL: asm_q holds a complete block. When out_q becomes free, asm_q moves to out_q on that edge, byte_cnt->0, go to COLLECT.
  - FULL, in_valid=1: the byte is dropped and overrun<=1. A drop that coincides with the transfer edge still counts as dropped.
- out_q is "free" when cipher_valid=0, or when cipher_valid=1 and cipher_ready=1 in the same cycle (pass-through). Back-to-back blocks therefore stream with no bubble under constant cipher_ready.
- Handshake rules:
  - cipher_out and cipher_valid are stable while cipher_valid=1 and cipher_ready=0.
  - cipher_valid drops the cycle after acceptance unless a new block loads on the same edge.
  - block_count increments on every valid & ready cycle.
- clr=1:
  - byte_cnt->0, asm_q->0, FSM->COLLECT, overrun->0.
  - A byte arriving in the same cycle is discarded.
  - out_q/cipher_valid are unaffected; a pending output block is still delivered.
  - In FULL, clr discards the held block.
- No arithmetic beyond counters. byte_cnt never exceeds BLOCK_BYTES-1; block_count wraps modulo 2^16.

Test Plan:
1. After reset, drive 16 consecutive bytes 0x00..0x0F with in_valid=1 and cipher_ready=1 (LSB_FIRST=1) -> one cycle after the last byte, cipher_valid=1 and cipher_out=128'h0F0E0D0C0B0A09080706050403020100; block_count=1 the cycle after.
2. Same stream with LSB_FIRST=0 -> cipher_out=128'h000102030405060708090A0B0C0D0E0F.
3. Hold cipher_ready=0 and send block A (all 0xAA) then block B (all 0xBB) -> cipher_out stays 0xAA.., state=FULL, byte_cnt=15. Raise cipher_ready for one cycle -> next cycle cipher_out=0xBB.., cipher_valid=1, block_count=1, overrun=0.
4. Continue from scenario 3 with cipher_ready=0, then send a 17th byte 0xCC while FULL -> overrun=1 (sticky); the 0xBB block is delivered intact afterwards.
5. Send 5 bytes, assert clr one cycle, then send 16 bytes 0x10..0x1F -> byte_cnt=0 after clr, overrun=0, cipher_out=128'h1F1E..10 with no trace of the first 5 bytes.
6. Assert rst mid-block (byte_cnt=7) with cipher_valid=1 -> next cycle all outputs return to reset values; a fresh 16-byte block then assembles correctly.
